// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing helpers for the boot-time instruction loader.
// CHK is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int HDR_LEN = 2;  // word-count header bytes, big-endian

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6,
    CHK   = 3'd7
  } state_t;

  function automatic int im_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word shifter: first byte lands in [31:24], word_full marks the 4th byte.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic        word_full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word      <= '0;
      idx       <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      word      <= '0;
      idx       <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word      <= {word[23:0], byte_in};
      idx       <= idx + 2'd1;
      word_full <= (idx == 2'd3);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> instruction memory, holding the core until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int DEPTH = im_depth(ADDR_W);

  state_t                     state, state_nx;
  logic [(HDR_LEN-1)*8-1:0]   cnt_hi;
  logic [CNT_W-1:0]           n_words;
  logic [CNT_W-1:0]           hdr_n;
  logic [ADDR_W:0]            cnt, cnt_inc;
  logic                       accept, go_start, last_word;
  logic [31:0]                asm_word;
  logic [1:0]                 asm_idx;
  logic                       asm_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                 xsum;
`endif

  assign byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
  assign accept     = byte_valid && byte_ready;
  assign go_start   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdr_n      = CNT_W'({cnt_hi, byte_data});
  assign cnt_inc    = cnt + 1'b1;
  assign last_word  = (CNT_W'(cnt_inc) == n_words);

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (go_start),
    .shift     (accept && (state == DATA)),
    .byte_in   (byte_data),
    .word      (asm_word),
    .idx       (asm_idx),
    .word_full (asm_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = HDR0;
      HDR0: if (accept) state_nx = HDR1;
      HDR1: if (accept) begin
        if (hdr_n == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
        else if (hdr_n > CNT_W'(DEPTH)) state_nx = ERR;
        else                            state_nx = DATA;
      end
      DATA: if (accept && (asm_idx == 2'd3)) state_nx = WRITE;
      WRITE: begin
        if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
        else
          state_nx = DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_nx = (byte_data == xsum) ? DONE : ERR;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_hi  <= '0;
      n_words <= '0;
      cnt     <= '0;
    end else begin
      if (go_start)                      cnt     <= '0;
      else if (state == WRITE)           cnt     <= cnt_inc;
      if (accept && (state == HDR0))     cnt_hi  <= byte_data;
      if (accept && (state == HDR1))     n_words <= hdr_n;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR covers data bytes only; the header is excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            xsum <= '0;
    else if (go_start)                   xsum <= '0;
    else if (accept && (state == DATA))  xsum <= xsum ^ byte_data;
  end
`endif

  // asm_full is set by the 4th byte and held through WRITE, so one strobe per word.
  assign im_we    = (state == WRITE) && asm_full;
  assign im_addr  = cnt[ADDR_W-1:0];
  assign im_wdata = asm_word;
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign word_cnt = cnt;

endmodule
